// File: rtl/snake_pkg.sv
// snake_pkg: shared definitions for the snake step controller.
//   - dir_t     : direction encoding (right/up/down/left). Opposites are
//                 bitwise complements, so reversal is a single inversion.
//   - state_t   : step FSM state encoding.
//   - GRID_*_DEF: default playfield size in cells.
//   - X_W/Y_W   : coordinate widths; LEN_W: body length width.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_UP    = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_CHECK = 3'd2,
    ST_MOVE  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int GRID_W_DEF = 20;
  localparam int GRID_H_DEF = 15;
  localparam int X_W        = 5;
  localparam int Y_W        = 4;
  localparam int LEN_W      = 5;

  // right<->left and up<->down are complementary codes.
  function automatic dir_t opposite_dir(input dir_t d);
    return dir_t'(~d);
  endfunction

  // Button vector to direction; lower bit index wins (right>up>down>left).
  // Only meaningful when at least one button is pressed.
  function automatic dir_t btn_to_dir(input logic [3:0] btn);
    if (btn[0])      return DIR_RIGHT;
    else if (btn[1]) return DIR_UP;
    else if (btn[2]) return DIR_DOWN;
    else             return DIR_LEFT;
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: free-running step timer.
//   clk   in  system clock
//   reset in  synchronous active-high reset (counter returns to 0)
//   tick  out high for the single cycle in which the count is TICK_CYCLES-1
module snake_tick_gen #(
  parameter int TICK_CYCLES = 8000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (count_reg == CNT_LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_ONE;
    end
  end

  assign tick = (count_reg == CNT_LAST);

endmodule

// File: rtl/snake_step_controller.sv
// snake_step_controller: snake game step engine.
//   Each tick advances the snake by one cell: CALC computes the next head
//   cell and samples food, CHECK resolves self-collision from the registered
//   grid lookup, MOVE commits body/grid updates. Head outputs change on the
//   third clock edge after the edge that samples the tick.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   btn_dir[3:0]             direction request [0]=right [1]=up [2]=down [3]=left
//   food_x/food_y/food_valid food cell and presence
//   rd_x/rd_y -> rd_occ      registered occupancy query (0 when out of range)
//   head_x/head_y, length    current head cell and body length
//   food_eaten               one-cycle pulse when food is consumed
//   game_over                sticky until reset
//   busy                     high while a step is in flight
// "Up" decreases y (display rows grow downward).
module snake_step_controller
  import snake_pkg::*;
#(
  parameter int GRID_W      = GRID_W_DEF,
  parameter int GRID_H      = GRID_H_DEF,
  parameter int MAX_LEN     = 16,
  parameter int TICK_CYCLES = 8000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       btn_dir,
  input  logic [X_W-1:0]   food_x,
  input  logic [Y_W-1:0]   food_y,
  input  logic             food_valid,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  output logic             rd_occ,
  output logic [X_W-1:0]   head_x,
  output logic [Y_W-1:0]   head_y,
  output logic [LEN_W-1:0] length,
  output logic             food_eaten,
  output logic             game_over,
  output logic             busy
);

  localparam int GRID_N = GRID_W * GRID_H;
  localparam int IDX_W  = $clog2(GRID_N);
  localparam int PTR_W  = $clog2(MAX_LEN);

  localparam logic [X_W-1:0]   START_X = X_W'(GRID_W / 2);
  localparam logic [Y_W-1:0]   START_Y = Y_W'(GRID_H / 2);
  localparam logic [X_W:0]     X_ONE   = (X_W+1)'(1);
  localparam logic [Y_W:0]     Y_ONE   = (Y_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  function automatic logic [IDX_W-1:0] cell_idx(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return IDX_W'(int'(y) * GRID_W + int'(x));
  endfunction

  state_t state_reg, state_next;
  dir_t   dir_reg, step_dir_reg, last_dir_reg;

  logic [GRID_N-1:0] grid_reg;
  logic [X_W-1:0]    body_x [MAX_LEN];
  logic [Y_W-1:0]    body_y [MAX_LEN];
  logic [PTR_W-1:0]  head_ptr_reg, tail_ptr_reg;
  logic [LEN_W-1:0]  length_reg;
  logic [X_W-1:0]    head_x_reg, next_x_reg, tail_x_reg;
  logic [Y_W-1:0]    head_y_reg, next_y_reg, tail_y_reg;
  logic              grow_reg, next_occ_reg, rd_occ_reg;
  logic              tick;

  snake_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // ---------------------------------------------------------------
  // Direction latch: reversal is only refused when a body exists.
  // ---------------------------------------------------------------
  dir_t btn_req;
  logic btn_reject;

  assign btn_req    = btn_to_dir(btn_dir);
  assign btn_reject = (length_reg != LEN_ONE) && (btn_req == opposite_dir(last_dir_reg));

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_reg <= DIR_RIGHT;
    end else if (state_reg != ST_OVER && btn_dir != 4'd0 && !btn_reject) begin
      dir_reg <= btn_req;
    end
  end

  // ---------------------------------------------------------------
  // Next-head computation, one bit wider so that 0-1 wraps to a value
  // that is necessarily out of range.
  // ---------------------------------------------------------------
  logic [X_W:0] calc_x;
  logic [Y_W:0] calc_y;
  logic         calc_oob;

  always_comb begin
    calc_x = {1'b0, head_x_reg};
    calc_y = {1'b0, head_y_reg};
    unique case (dir_reg)
      DIR_RIGHT: calc_x = {1'b0, head_x_reg} + X_ONE;
      DIR_UP:    calc_y = {1'b0, head_y_reg} - Y_ONE;
      DIR_DOWN:  calc_y = {1'b0, head_y_reg} + Y_ONE;
      DIR_LEFT:  calc_x = {1'b0, head_x_reg} - X_ONE;
    endcase
    calc_oob = (calc_x >= (X_W+1)'(GRID_W)) || (calc_y >= (Y_W+1)'(GRID_H));
  end

  logic rd_in_range;
  assign rd_in_range = ({1'b0, rd_x} < (X_W+1)'(GRID_W)) &&
                       ({1'b0, rd_y} < (Y_W+1)'(GRID_H));

  // ---------------------------------------------------------------
  // Step FSM: next state and status outputs.
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    food_eaten = 1'b0;
    game_over  = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (tick) state_next = ST_CALC;
      end
      ST_CALC: begin
        busy       = 1'b1;
        state_next = calc_oob ? ST_OVER : ST_CHECK;
      end
      ST_CHECK: begin
        busy = 1'b1;
        // Entering the tail cell is legal when the tail vacates it this step.
        if (next_occ_reg &&
            !(next_x_reg == tail_x_reg && next_y_reg == tail_y_reg && !grow_reg))
          state_next = ST_OVER;
        else
          state_next = ST_MOVE;
      end
      ST_MOVE: begin
        busy       = 1'b1;
        food_eaten = grow_reg;
        state_next = ST_IDLE;
      end
      ST_OVER: begin
        game_over = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // State register, grid, ring buffer and head/tail bookkeeping.
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      step_dir_reg <= DIR_RIGHT;
      last_dir_reg <= DIR_RIGHT;
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      length_reg   <= LEN_ONE;
      head_x_reg   <= START_X;
      head_y_reg   <= START_Y;
      next_x_reg   <= '0;
      next_y_reg   <= '0;
      tail_x_reg   <= '0;
      tail_y_reg   <= '0;
      grow_reg     <= 1'b0;
      next_occ_reg <= 1'b0;
      rd_occ_reg   <= 1'b0;
      body_x[0]    <= START_X;
      body_y[0]    <= START_Y;
      grid_reg     <= '0;
      grid_reg[cell_idx(START_X, START_Y)] <= 1'b1;
    end else begin
      state_reg  <= state_next;
      // Reads the pre-update grid, so a same-cycle MOVE is not visible yet.
      rd_occ_reg <= rd_in_range ? grid_reg[cell_idx(rd_x, rd_y)] : 1'b0;

      unique case (state_reg)
        ST_CALC: begin
          next_x_reg   <= calc_x[X_W-1:0];
          next_y_reg   <= calc_y[Y_W-1:0];
          step_dir_reg <= dir_reg;
          grow_reg     <= food_valid && (calc_x[X_W-1:0] == food_x) &&
                          (calc_y[Y_W-1:0] == food_y);
          next_occ_reg <= grid_reg[cell_idx(calc_x[X_W-1:0], calc_y[Y_W-1:0])];
          // Tail is captured here because a full ring overwrites its slot in MOVE.
          tail_x_reg   <= body_x[tail_ptr_reg];
          tail_y_reg   <= body_y[tail_ptr_reg];
        end
        ST_MOVE: begin
          if (!grow_reg || length_reg == LEN_MAX) begin
            grid_reg[cell_idx(tail_x_reg, tail_y_reg)] <= 1'b0;
            tail_ptr_reg <= tail_ptr_reg + PTR_ONE;
          end else begin
            length_reg <= length_reg + LEN_ONE;
          end
          // Issued after the tail clear so a shared cell ends up set.
          grid_reg[cell_idx(next_x_reg, next_y_reg)] <= 1'b1;
          body_x[head_ptr_reg + PTR_ONE] <= next_x_reg;
          body_y[head_ptr_reg + PTR_ONE] <= next_y_reg;
          head_ptr_reg <= head_ptr_reg + PTR_ONE;
          head_x_reg   <= next_x_reg;
          head_y_reg   <= next_y_reg;
          last_dir_reg <= step_dir_reg;
        end
        default: ;
      endcase
    end
  end

  assign rd_occ = rd_occ_reg;
  assign head_x = head_x_reg;
  assign head_y = head_y_reg;
  assign length = length_reg;

endmodule

// File: doc/snake_step_controller.md
SNAKE_STEP_CONTROLLER -- requirements
Module: snake_step_controller

Interface
REQ-001 Parameter GRID_W, default 20, grid width in cells (display cell = 32x32 px).
REQ-002 Parameter GRID_H, default 15, grid height in cells.
REQ-003 Parameter MAX_LEN, default 16, body ring-buffer depth (power of 2).
REQ-004 Parameter TICK_CYCLES, default 8000000, clk cycles per snake step; legal minimum 8.
REQ-005 clk  in  1  single system clock (pixel PLL output).
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 btn_dir  in  4  direction request, active-high, debounced: [0]=right [1]=up [2]=down [3]=left.
REQ-008 food_x / food_y  in  5 / 4  food cell coordinate; food_valid  in  1  food present.
REQ-009 rd_x / rd_y  in  5 / 4  display-side cell query; rd_occ  out  1  occupancy of queried cell.
REQ-010 head_x / head_y  out  5 / 4  current head cell; length  out  5  body length, 1..MAX_LEN.
REQ-011 food_eaten  out  1  one-cycle pulse; game_over  out  1  sticky level; busy  out  1  step in progress.

Function
REQ-012 Free-running tick counter, 0..TICK_CYCLES-1; tick asserted one cycle at TICK_CYCLES-1, then wraps to 0.
REQ-013 Direction latch updates every cycle; multiple buttons resolved by priority right>up>down>left.
REQ-014 Request exactly opposite the direction applied at the last step is ignored when length>1; accepted when length==1.
REQ-015 FSM states: IDLE, CALC, CHECK, MOVE, OVER; busy=1 in CALC/CHECK/MOVE.
REQ-016 IDLE->CALC on tick; ticks arriving outside IDLE are dropped.
REQ-017 CALC: next = head + latched direction; next outside 0..GRID_W-1 / 0..GRID_H-1 (incl. unsigned wrap below 0) -> OVER.
REQ-018 CALC: grow = food_valid && next==food, sampled this cycle; else grid read of next issued -> CHECK.
REQ-019 CHECK: next occupied and not (next==tail && !grow) -> OVER; otherwise -> MOVE.
REQ-020 MOVE, non-grow: clear grid bit at tail, advance tail pointer mod MAX_LEN.
REQ-021 MOVE, grow and length<MAX_LEN: tail unchanged, length+1; grow at MAX_LEN behaves as non-grow.
REQ-022 MOVE, grow: food_eaten pulses exactly one cycle regardless of length cap.
REQ-023 MOVE: store next at head pointer+1 (mod MAX_LEN), advance head pointer, set grid bit at next, update head_x/head_y; -> IDLE.
REQ-024 Tail-clear and head-set to the same cell in one MOVE: cell ends set.
REQ-025 Step latency: tick to updated head_x/head_y = 3 cycles.
REQ-026 rd_occ registered: reflects grid contents one cycle after rd_x/rd_y; same-cycle write gives pre-write value; out-of-range query returns 0.
REQ-027 OVER: grid, pointers, outputs frozen; game_over=1; exit only by reset.

Reset
REQ-028 Reset, any state incl. mid-step: FSM IDLE, tick counter 0, direction right, length 1, head=tail pointer 0.
REQ-029 Reset: head_x=GRID_W/2, head_y=GRID_H/2, grid all zero except head cell, food_eaten=0, game_over=0, busy=0, rd_occ=0.

Structure
REQ-030 Package snake_pkg holds direction encoding, GRID_W/GRID_H defaults, coordinate widths and FSM state encoding.
REQ-031 Tick counter is sub-module snake_tick_gen (TICK_CYCLES parameter, outputs tick); grid and ring buffer stay in this module.

Verification (TICK_CYCLES=10)
REQ-032 Reset, no buttons, 3 ticks -> head (10,7)->(11,7)->(12,7)->(13,7), length 1, rd_occ at (13,7)=1, at (12,7)=0.
REQ-033 food (12,7) valid, heading right -> food_eaten one pulse on 2nd step, length 2, cells (11,7),(12,7) set.
REQ-034 Length 2 heading right, btn_dir=left -> ignored, head (13,7); btn_dir=4'b1111 -> right wins.
REQ-035 Drive right until x=19, one more tick -> game_over=1, head stays (19,7), later ticks change nothing.
REQ-036 Length 4 in 2x2 loop: step into vacated tail cell -> legal; length 5 into own body -> game_over=1.
REQ-037 Assert reset during CHECK -> next cycle busy=0, head (10,7), length 1, only (10,7) occupied.
